mod_mul_serial: RTL and testbench
=================================

MOD_MUL_SERIAL -- requirements
Module: mod_mul_serial

Interface
REQ-001 The block SHALL have parameter BITWIDTH, default 32, giving the width of operands, modulus and result.
REQ-002 The block SHALL have port iClk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port iRstN, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port iEn, input, 1 bit: clock enable; when low, all state holds.
REQ-005 The block SHALL have port iClr, input, 1 bit: synchronous abort/clear.
REQ-006 The block SHALL have port iStart, input, 1 bit: start request, sampled per REQ-012.
REQ-007 The block SHALL have ports iA, iB, iMod, each input, BITWIDTH bits: multiplicand, multiplier and modulus.
REQ-008 The block SHALL have port oBusy, output, 1 bit: high while the computation is in progress.
REQ-009 The block SHALL have port oDone, output, 1 bit: single-cycle completion pulse.
REQ-010 The block SHALL have port oData, output, BITWIDTH bits: registered result (iA*iB) mod iMod.

Function
REQ-011 The block SHALL implement a 3-state FSM: IDLE, RUN, DONE.
REQ-012 A start SHALL be accepted when iEn=1, iClr=0, iStart=1 and state is IDLE or DONE; iStart SHALL be ignored in RUN.
REQ-013 On start acceptance, the block SHALL capture iA, iB and iMod into internal registers, clear the accumulator to 0, load the bit counter with BITWIDTH-1, and enter RUN.
REQ-014 After capture, input changes SHALL NOT affect the result.
REQ-015 Each enabled RUN cycle SHALL process one bit of captured B, MSB first: acc <= mod(mod(2*acc) + (b_i ? A : 0)).
REQ-016 mod(x) in REQ-015 SHALL be one conditional subtract of M.
REQ-017 Intermediate sums SHALL be BITWIDTH+1 bits wide so that no overflow occurs for any M up to 2^BITWIDTH-1.
REQ-018 RUN SHALL last exactly BITWIDTH enabled cycles; after the bit-0 step, the FSM SHALL enter DONE and oData SHALL load the accumulator.
REQ-019 oDone SHALL be high exactly in the DONE cycle, with oData valid in that same cycle.
REQ-020 Latency SHALL be as follows: with start accepted at edge t and iEn held high, oDone is high in the cycle after edge t+BITWIDTH.
REQ-021 DONE SHALL last one enabled cycle, then go to IDLE; a start accepted in DONE SHALL go directly to RUN (back-to-back operation).
REQ-022 oData SHALL hold its value from DONE until the next DONE, iClr or reset.
REQ-023 oBusy SHALL be 1 exactly while state is RUN.
REQ-024 When iEn=0, state, counter, accumulator and outputs SHALL hold, including oDone: a pulse stretches while stalled.
REQ-025 iClr=1 SHALL act regardless of iEn and SHALL force state to IDLE, oData to 0, oBusy to 0 and oDone to 0, aborting any operation.
REQ-026 When iClr=1 and iStart=1 in the same cycle, iClr SHALL win and the start SHALL be dropped.
REQ-027 For contract inputs iA<iMod and iB<iMod, oData SHALL equal (iA*iB) mod iMod exactly.
REQ-028 When iMod=1, the result SHALL be 0.
REQ-029 When iMod=0 or an operand is >= iMod, the value of oData SHALL be unspecified, but the FSM timing and handshake SHALL be unchanged and no lock-up SHALL occur.

Reset
REQ-030 When iRstN=0 at a rising edge, the block SHALL reset: state IDLE, oData=0, oBusy=0, oDone=0, and all internal registers 0.
REQ-031 Reset SHALL have priority over iClr, iEn and iStart.
REQ-032 Reset asserted mid-RUN SHALL abort the operation, with no oDone for that operation.

Verification (BITWIDTH=8)
REQ-033 The bench SHALL apply iA=5, iB=7, iMod=11 with a 1-cycle iStart and iEn=1 -> oBusy high for 8 cycles, oDone high in cycle 9 after start, oData=2.
REQ-034 The bench SHALL apply iA=254, iB=254, iMod=255 -> oData=1, checking the no-overflow path; iA=0, iB=200, iMod=251 -> oData=0; iMod=1, iA=0, iB=0 -> oData=0.
REQ-035 The bench SHALL apply iA=5, iB=7, iMod=11 with iEn=0 for 3 cycles mid-RUN -> oDone delayed by exactly 3 cycles, oData=2; a second iStart during RUN is ignored.
REQ-036 The bench SHALL apply a start of 5*7 mod 11, then in the DONE cycle a start of 3*4 mod 7 -> first oData=2, then after another 9 cycles oData=5.
REQ-037 The bench SHALL assert iClr in the 4th RUN cycle -> next cycle oBusy=0, oData=0, no oDone; a subsequent start of 5*7 mod 11 -> oData=2.
REQ-038 The bench SHALL assert iRstN=0 mid-RUN -> all outputs 0 at the next edge, no oDone; while iRstN=0 an iStart pulse has no effect.

Source files
------------

// File: rtl/mod_mul_serial.sv
// rtl/mod_mul_serial.sv - bit-serial modular multiplier, (A*B) mod M, MSB-first double-and-add
module mod_mul_serial #(
  parameter int BITWIDTH = 32
) (
  input  logic                iClk,
  input  logic                iRstN,
  input  logic                iEn,
  input  logic                iClr,
  input  logic                iStart,
  input  logic [BITWIDTH-1:0] iA,
  input  logic [BITWIDTH-1:0] iB,
  input  logic [BITWIDTH-1:0] iMod,
  output logic                oBusy,
  output logic                oDone,
  output logic [BITWIDTH-1:0] oData
);

  localparam int CW = (BITWIDTH > 1) ? $clog2(BITWIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q;
  logic [BITWIDTH-1:0] a_q;
  logic [BITWIDTH-1:0] b_q;
  logic [BITWIDTH-1:0] m_q;
  logic [BITWIDTH-1:0] acc_q;
  logic [BITWIDTH-1:0] data_q;
  logic [CW-1:0]       cnt_q;
  logic                busy_q;
  logic                done_q;

  logic [BITWIDTH:0]   dbl;
  logic [BITWIDTH-1:0] dbl_red;
  logic [BITWIDTH-1:0] addend;
  logic [BITWIDTH:0]   sum;
  logic [BITWIDTH-1:0] acc_d;
  logic                start_ok;

  // One MSB-first step; sums carry an extra bit so M near 2^BITWIDTH cannot overflow.
  always_comb begin
    dbl     = {acc_q, 1'b0};
    dbl_red = (dbl >= {1'b0, m_q}) ? BITWIDTH'(dbl - {1'b0, m_q}) : dbl[BITWIDTH-1:0];
    addend  = b_q[BITWIDTH-1] ? a_q : '0;
    sum     = {1'b0, dbl_red} + {1'b0, addend};
    acc_d   = (sum >= {1'b0, m_q}) ? BITWIDTH'(sum - {1'b0, m_q}) : sum[BITWIDTH-1:0];
  end

  assign start_ok = iEn && !iClr && iStart && (state_q != RUN);

  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
      acc_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (iClr) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (iEn) begin
      if (start_ok) begin
        a_q     <= iA;
        b_q     <= iB;
        m_q     <= iMod;
        acc_q   <= '0;
        cnt_q   <= CW'(BITWIDTH - 1);
        state_q <= RUN;
        busy_q  <= 1'b1;
        done_q  <= 1'b0;
      end else begin
        case (state_q)
          RUN: begin
            acc_q <= acc_d;
            b_q   <= b_q << 1;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == '0) begin
              state_q <= DONE;
              data_q  <= acc_d;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
          DONE: begin
            state_q <= IDLE;
            done_q  <= 1'b0;
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign oBusy = busy_q;
  assign oDone = done_q;
  assign oData = data_q;

endmodule

// File: tb/tb_mod_mul_serial.sv
// tb/tb_mod_mul_serial.sv - scoreboard bench for mod_mul_serial at BITWIDTH=8
module tb_mod_mul_serial;

  localparam int W = 8;

  logic         iClk   = 1'b0;
  logic         iRstN  = 1'b0;
  logic         iEn    = 1'b0;
  logic         iClr   = 1'b0;
  logic         iStart = 1'b0;
  logic [W-1:0] iA     = '0;
  logic [W-1:0] iB     = '0;
  logic [W-1:0] iMod   = '0;
  logic         oBusy;
  logic         oDone;
  logic [W-1:0] oData;

  mod_mul_serial #(.BITWIDTH(W)) dut (
    .iClk   (iClk),
    .iRstN  (iRstN),
    .iEn    (iEn),
    .iClr   (iClr),
    .iStart (iStart),
    .iA     (iA),
    .iB     (iB),
    .iMod   (iMod),
    .oBusy  (oBusy),
    .oDone  (oDone),
    .oData  (oData)
  );

  always #5 iClk = ~iClk;

  int cyc = 0;
  always @(posedge iClk) cyc <= cyc + 1;

  int           n_checks  = 0;
  int           n_fail    = 0;
  int           start_cyc = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_v;
  logic         prev_done = 1'b0;

  // Each new completion pulse consumes one expected result; a stretched pulse counts once.
  always @(negedge iClk) begin
    if (iRstN && oDone === 1'b1 && !prev_done) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_done: oData=%0d at cycle %0d, required no completion", oData, cyc);
      end else begin
        exp_v = exp_q.pop_front();
        if (oData !== exp_v) begin
          n_fail++;
          $display("FAIL sb_data: oData=%0d required %0d at cycle %0d", oData, exp_v, cyc);
        end
      end
    end
    prev_done = (oDone === 1'b1);
  end

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic start_op(input int a, input int b, input int m, input bit push);
    iA = W'(a); iB = W'(b); iMod = W'(m); iStart = 1'b1;
    tick();
    iStart = 1'b0;
    start_cyc = cyc;
    if (push) exp_q.push_back(W'((a * b) % m));
    iA = W'($urandom); iB = W'($urandom); iMod = W'($urandom);
  endtask

  task automatic wait_done(output int lat);
    for (int i = 0; i < 100 && oDone !== 1'b1; i++) tick();
    lat = cyc - start_cyc;
    n_checks++;
    if (oDone !== 1'b1) begin
      n_fail++;
      $display("FAIL done_timeout: oDone=%b required 1 within 100 cycles", oDone);
    end
  endtask

  task automatic test_reset();
    iRstN = 1'b0; iStart = 1'b1; iEn = 1'b1; iA = 8'd5; iB = 8'd7; iMod = 8'd11;
    tick(); tick();
    n_checks += 3;
    if (oBusy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: oBusy=%b required 0", oBusy); end
    if (oDone !== 1'b0) begin n_fail++; $display("FAIL reset_done: oDone=%b required 0", oDone); end
    if (oData !== '0) begin n_fail++; $display("FAIL reset_data: oData=%0d required 0", oData); end
    iStart = 1'b0; iRstN = 1'b1;
    tick();
    n_checks++;
    if (oBusy !== 1'b0) begin n_fail++; $display("FAIL reset_start_ignored: oBusy=%b required 0", oBusy); end
  endtask

  task automatic test_basic();
    start_op(5, 7, 11, 1'b1);
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (oBusy !== 1'b1 || oDone !== 1'b0) begin
        n_fail++;
        $display("FAIL basic_run%0d: oBusy=%b oDone=%b required 1/0", i, oBusy, oDone);
      end
      tick();
    end
    n_checks += 3;
    if (oDone !== 1'b1 || oBusy !== 1'b0) begin n_fail++; $display("FAIL basic_done: oDone=%b oBusy=%b required 1/0", oDone, oBusy); end
    if (oData !== 8'd2) begin n_fail++; $display("FAIL basic_data: oData=%0d required 2", oData); end
    if (cyc - start_cyc != 8) begin n_fail++; $display("FAIL basic_latency: %0d required 8", cyc - start_cyc); end
    tick();
    n_checks++;
    if (oDone !== 1'b0 || oData !== 8'd2) begin n_fail++; $display("FAIL basic_hold: oDone=%b oData=%0d required 0/2", oDone, oData); end
  endtask

  task automatic test_corners();
    int vec[7][3];
    int lat;
    int e;
    vec[0] = '{254, 254, 255}; vec[1] = '{0, 200, 251}; vec[2] = '{0, 0, 1};
    for (int k = 3; k < 7; k++) begin
      vec[k][2] = int'($urandom_range(2, 255));
      vec[k][0] = int'($urandom_range(0, vec[k][2] - 1));
      vec[k][1] = int'($urandom_range(0, vec[k][2] - 1));
    end
    for (int k = 0; k < 7; k++) begin
      e = (vec[k][0] * vec[k][1]) % vec[k][2];
      start_op(vec[k][0], vec[k][1], vec[k][2], 1'b1);
      wait_done(lat);
      n_checks += 2;
      if (lat != 8) begin n_fail++; $display("FAIL corner%0d_latency: %0d required 8", k, lat); end
      if (oData !== W'(e)) begin n_fail++; $display("FAIL corner%0d_data: oData=%0d required %0d", k, oData, e); end
      tick();
    end
  endtask

  task automatic test_stall();
    int lat;
    start_op(5, 7, 11, 1'b1);
    tick();
    iStart = 1'b1; iA = 8'd1; iB = 8'd1; iMod = 8'd3;
    tick();
    iStart = 1'b0;
    tick();
    iEn = 1'b0;
    tick(); tick(); tick();
    n_checks++;
    if (oBusy !== 1'b1) begin n_fail++; $display("FAIL stall_busy: oBusy=%b required 1", oBusy); end
    iEn = 1'b1;
    wait_done(lat);
    n_checks += 2;
    if (lat != 11) begin n_fail++; $display("FAIL stall_latency: %0d required 11", lat); end
    if (oData !== 8'd2) begin n_fail++; $display("FAIL stall_data: oData=%0d required 2", oData); end
    iEn = 1'b0;
    tick(); tick();
    n_checks++;
    if (oDone !== 1'b1) begin n_fail++; $display("FAIL stall_stretch: oDone=%b required 1", oDone); end
    iEn = 1'b1;
    tick();
    n_checks++;
    if (oDone !== 1'b0 || oBusy !== 1'b0) begin n_fail++; $display("FAIL stall_release: oDone=%b oBusy=%b required 0/0", oDone, oBusy); end
  endtask

  task automatic test_back_to_back();
    int lat;
    start_op(5, 7, 11, 1'b1);
    wait_done(lat);
    n_checks++;
    if (oData !== 8'd2) begin n_fail++; $display("FAIL b2b_first: oData=%0d required 2", oData); end
    start_op(3, 4, 7, 1'b1);
    n_checks++;
    if (oBusy !== 1'b1 || oDone !== 1'b0) begin n_fail++; $display("FAIL b2b_restart: oBusy=%b oDone=%b required 1/0", oBusy, oDone); end
    wait_done(lat);
    n_checks += 2;
    if (lat != 8) begin n_fail++; $display("FAIL b2b_latency: %0d required 8", lat); end
    if (oData !== 8'd5) begin n_fail++; $display("FAIL b2b_second: oData=%0d required 5", oData); end
    tick();
  endtask

  task automatic test_clear();
    int lat;
    bit seen;
    start_op(5, 7, 11, 1'b0);
    tick(); tick(); tick();
    iClr = 1'b1; iStart = 1'b1; iEn = 1'b0;
    tick();
    iClr = 1'b0; iStart = 1'b0; iEn = 1'b1;
    n_checks++;
    if (oBusy !== 1'b0 || oData !== '0 || oDone !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_abort: oBusy=%b oData=%0d oDone=%b required 0/0/0", oBusy, oData, oDone);
    end
    iClr = 1'b1; iStart = 1'b1; iA = 8'd5; iB = 8'd7; iMod = 8'd11;
    tick();
    iClr = 1'b0; iStart = 1'b0;
    n_checks++;
    if (oBusy !== 1'b0) begin n_fail++; $display("FAIL clr_wins_start: oBusy=%b required 0", oBusy); end
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (oDone === 1'b1 || oBusy === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin n_fail++; $display("FAIL clr_no_done: activity=%b required 0", seen); end
    start_op(5, 7, 11, 1'b1);
    wait_done(lat);
    n_checks++;
    if (oData !== 8'd2) begin n_fail++; $display("FAIL clr_restart: oData=%0d required 2", oData); end
    tick();
  endtask

  task automatic test_reset_mid();
    bit seen;
    start_op(5, 7, 11, 1'b0);
    tick(); tick();
    iRstN = 1'b0;
    tick();
    n_checks++;
    if (oBusy !== 1'b0 || oDone !== 1'b0 || oData !== '0) begin
      n_fail++;
      $display("FAIL rst_mid: oBusy=%b oDone=%b oData=%0d required 0/0/0", oBusy, oDone, oData);
    end
    iStart = 1'b1; iA = 8'd5; iB = 8'd7; iMod = 8'd11;
    tick();
    iStart = 1'b0;
    n_checks++;
    if (oBusy !== 1'b0) begin n_fail++; $display("FAIL rst_start_ignored: oBusy=%b required 0", oBusy); end
    iRstN = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (oDone === 1'b1 || oBusy === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin n_fail++; $display("FAIL rst_no_done: activity=%b required 0", seen); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_stall();
    test_back_to_back();
    test_clear();
    test_reset_mid();
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL sb_drain: %0d results outstanding, required 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
